// File: rtl/fifo_word_packer.sv
// Packs bytes read from an upstream byte FIFO into little-endian 32-bit words.
// Define FIFO_WORD_PACKER_FLUSH_EN to allow flush to emit partial words.
module fifo_word_packer #(
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        fifo_r_en,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_underflow,
  input  logic        flush,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [2:0]  m_bytes,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam logic [2:0] FULL      = 3'd4;
  localparam logic [2:0] WAIT_CYC  = 3'(RD_LATENCY - 1);
  localparam logic       SKIP_WAIT = (RD_LATENCY == 1);

`ifdef FIFO_WORD_PACKER_FLUSH_EN
  localparam logic FLUSH_EN = 1'b1;
`else
  localparam logic FLUSH_EN = 1'b0;
`endif

  logic [2:0]  state_r;
  logic [2:0]  next_s;
  logic [2:0]  fill_r;
  logic [2:0]  fill_nx_s;
  logic [2:0]  wait_cnt_r;
  logic [31:0] lanes_r;
  logic        armed_r;
  logic        flush_req_s;
  logic        fifo_r_en_r;
  logic        m_valid_r;
  logic [2:0]  m_bytes_r;
  logic        err_r;

  assign flush_req_s = flush & FLUSH_EN;

  // Next-state and next-fill decode for the read/capture/output sequence.
  always_comb begin
    next_s    = state_r;
    fill_nx_s = fill_r;
    case (state_r)
      S_IDLE: begin
        // armed_r holds off the first read until the second edge after reset
        if (!armed_r) begin
          next_s = S_IDLE;
        end else if (!fifo_empty && (fill_r < FULL)) begin
          next_s = S_REQ;
        end else if (flush_req_s && (fill_r != 3'd0)) begin
          next_s = S_OUT;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (SKIP_WAIT) begin
          next_s = S_CAP;
        end else begin
          next_s = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_r <= 3'd1) begin
          next_s = S_CAP;
        end else begin
          next_s = S_WAIT;
        end
      end
      S_CAP: begin
        fill_nx_s = fill_r + 3'd1;
        if (fill_nx_s == FULL) begin
          next_s = S_OUT;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_OUT: begin
        if (m_ready) begin
          next_s    = S_IDLE;
          fill_nx_s = 3'd0;
        end else begin
          next_s = S_OUT;
        end
      end
      default: begin
        next_s    = S_IDLE;
        fill_nx_s = 3'd0;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs track the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      fill_r      <= 3'd0;
      wait_cnt_r  <= 3'd0;
      lanes_r     <= 32'd0;
      armed_r     <= 1'b0;
      fifo_r_en_r <= 1'b0;
      m_valid_r   <= 1'b0;
      m_bytes_r   <= 3'd0;
      err_r       <= 1'b0;
    end else begin
      state_r <= next_s;
      fill_r  <= fill_nx_s;
      armed_r <= 1'b1;
      err_r   <= err_r | fifo_underflow;

      if (state_r == S_REQ) begin
        wait_cnt_r <= WAIT_CYC;
      end else if (state_r == S_WAIT) begin
        wait_cnt_r <= wait_cnt_r - 3'd1;
      end

      if (state_r == S_CAP) begin
        lanes_r[{fill_r[1:0], 3'b000} +: 8] <= fifo_dout;
      end else if ((state_r == S_OUT) && m_ready) begin
        lanes_r <= 32'd0;
      end

      fifo_r_en_r <= (next_s == S_REQ);
      m_valid_r   <= (next_s == S_OUT);
      if (next_s == S_OUT) begin
        m_bytes_r <= FLUSH_EN ? fill_nx_s : FULL;
      end else begin
        m_bytes_r <= 3'd0;
      end
    end
  end

  assign fifo_r_en = fifo_r_en_r;
  assign m_valid   = m_valid_r;
  assign m_data    = lanes_r;
  assign m_bytes   = m_bytes_r;
  assign err       = err_r;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: table of full words plus hand-written
// sequences for reset release, flush, underflow and reset during a read.
module tb_fifo_word_packer;

  localparam int RD_LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty = 1'b1;
  logic        fifo_r_en;
  logic [7:0]  fifo_dout = 8'hEE;
  logic        fifo_underflow;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [2:0]  m_bytes;
  logic        err;

  int checks   = 0;
  int failures = 0;

  fifo_word_packer #(.RD_LATENCY(RD_LATENCY)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_r_en      (fifo_r_en),
    .fifo_dout      (fifo_dout),
    .fifo_underflow (fifo_underflow),
    .flush          (flush),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_bytes        (m_bytes),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: data appears only in the cycle RD_LATENCY after the strobe.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pend_cnt = 0;
  logic [7:0] pend_data = 8'hEE;

  always @(negedge clk) begin
    fifo_dout = 8'hEE;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) fifo_dout = pend_data;
    end
    if (fifo_r_en === 1'b1) begin
      if (rd_ptr != wr_ptr) begin
        pend_data = mem[rd_ptr];
        rd_ptr = rd_ptr + 1;
      end else begin
        pend_data = 8'hEE;
      end
      pend_cnt = RD_LATENCY;
    end
    fifo_empty = (rd_ptr == wr_ptr);
  end

  // Strobe monitor: counts read pulses and checks their spacing.
  int ren_total = 0;
  int cyc = 0;
  int last_ren = -1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (fifo_r_en === 1'b1) begin
      ren_total = ren_total + 1;
      if (last_ren >= 0) begin
        checks = checks + 1;
        if ((cyc - last_ren) < (2 + RD_LATENCY)) begin
          failures = failures + 1;
          $display("FAIL ren_spacing actual=%0d required>=%0d", cyc - last_ren, 2 + RD_LATENCY);
        end
      end
      last_ren = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) break;
    end
    check(name, {31'd0, m_valid}, 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_r_en"},  {31'd0, fifo_r_en}, 32'd0);
    check({tag, "_valid"}, {31'd0, m_valid},   32'd0);
    check({tag, "_data"},  m_data,             32'd0);
    check({tag, "_bytes"}, {29'd0, m_bytes},   32'd0);
    check({tag, "_err"},   {31'd0, err},       32'd0);
  endtask

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    int          hold;
    logic [31:0] exp_data;
    logic [2:0]  exp_bytes;
  } vec_t;

  task automatic run_word(input vec_t v);
    int start;
    int snap;
    start = ren_total;
    m_ready = (v.hold == 0);
    push(v.b0);
    push(v.b1);
    push(v.b2);
    push(v.b3);
    wait_valid("word_valid");
    check("word_data",  m_data,             v.exp_data);
    check("word_bytes", {29'd0, m_bytes},   {29'd0, v.exp_bytes});
    snap = ren_total;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, m_valid}, 32'd1);
      check("hold_data",  m_data,           v.exp_data);
    end
    check("hold_no_r_en", ren_total, snap);
    m_ready = 1'b1;
    @(negedge clk);
    check("after_hs_valid", {31'd0, m_valid}, 32'd0);
    check("after_hs_data",  m_data,           32'd0);
    m_ready = 1'b0;
    @(negedge clk);
    check("single_hs", {31'd0, m_valid}, 32'd0);
    check("word_r_en_pulses", ren_total - start, 32'd4);
  endtask

  vec_t vecs [3];
  vec_t post;
  int start;
  int seen;

  initial begin
    vecs[0] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 0,  32'hEFBEADDE, 3'd4};
    vecs[1] = '{8'h00, 8'hFF, 8'h80, 8'h01, 10, 32'h0180FF00, 3'd4};
    vecs[2] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 3,  32'hC33CA55A, 3'd4};
    post    = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 0,  32'hA4A3A2A1, 3'd4};

    rst = 1'b1;
    m_ready = 1'b0;
    flush = 1'b0;
    fifo_underflow = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");

    // First word: bytes waiting at reset release, read no earlier than edge two.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    m_ready = 1'b1;
    @(negedge clk);
    start = ren_total;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_edge1_r_en", {31'd0, fifo_r_en}, 32'd0);
    @(posedge clk); #1;
    check("rel_edge2_r_en", {31'd0, fifo_r_en}, 32'd1);
    wait_valid("first_valid");
    check("first_data",  m_data,           32'h44332211);
    check("first_bytes", {29'd0, m_bytes}, 32'd4);
    @(negedge clk);
    check("first_hs_valid", {31'd0, m_valid}, 32'd0);
    m_ready = 1'b0;
    @(negedge clk);
    check("first_r_en_pulses", ren_total - start, 32'd4);

    for (int i = 0; i < 3; i++) run_word(vecs[i]);

    // Two bytes, then flush from IDLE.
    start = ren_total;
    push(8'hAA); push(8'hBB);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ren_total - start >= 2) break;
    end
    check("flush_reads", ren_total - start, 32'd2);
    repeat (6) @(negedge clk);
    check("pre_flush_valid", {31'd0, m_valid}, 32'd0);
    flush = 1'b1;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    wait_valid("flush_valid");
    check("flush_data",  m_data,           32'h0000BBAA);
    check("flush_bytes", {29'd0, m_bytes}, 32'd2);
    flush = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("flush_hs_valid", {31'd0, m_valid}, 32'd0);
    m_ready = 1'b0;
    flush = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen++;
    end
    check("flush_empty_ignored", seen, 32'd0);
    flush = 1'b0;
`else
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid === 1'b1) seen++;
    end
    check("flush_disabled_no_out", seen, 32'd0);
    flush = 1'b0;
`endif

    // Sticky error from an underflow pulse, cleared only by reset.
    @(negedge clk);
    check("err_before", {31'd0, err}, 32'd0);
    fifo_underflow = 1'b1;
    @(negedge clk);
    fifo_underflow = 1'b0;
    @(negedge clk);
    check("err_set", {31'd0, err}, 32'd1);
    repeat (5) @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1;
    #1;
    check_zero_outputs("err_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while the second byte is in flight.
    push(8'h01); push(8'h02);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_r_en === 1'b1) seen++;
      if (seen == 2) break;
    end
    check("wait_rst_reads", seen, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_zero_outputs("wait_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_word(post);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
